// File: rtl/key_load_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_load_pkg
// Description : Shared types and sizing helpers for the key load sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package key_load_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_FAIL   = 3'd4
    } state_e;

    // Number of stream words that make up one key
    function automatic int nwords(input int key_w, input int word_w);
        return key_w / word_w;
    endfunction

    // Word counter width; never collapses to zero bits for a one-word key
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_KEY_W  = 32;
    localparam int DEF_WORD_W = 8;
    localparam int DEF_NWORDS = nwords(DEF_KEY_W, DEF_WORD_W);
    localparam int DEF_CNT_W  = cnt_width(DEF_NWORDS);

endpackage
`default_nettype wire

// File: rtl/key_tag_accum.sv
`default_nettype none
// ============================================================================
// Module      : key_tag_accum
// Description : XOR-fold accumulator over the key stream; clear wins over
//               enable.
// Revision    : 1.0 - initial release
// ============================================================================
module key_tag_accum #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [WORD_W-1:0] data_i,
    output logic [WORD_W-1:0] acc_o
);

    logic [WORD_W-1:0] acc_q;

    // Fold each accepted word into the running XOR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q ^ data_i;
        end
    end

    assign acc_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/key_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : key_load_ctrl
// Description : Loads the unlock key for a logic-locked core from the NVM
//               key stream, verifies the XOR tag and commits the key
//               atomically. Core outputs stay gated until a verified key is
//               present.
// Revision    : 1.0 - initial release
// ============================================================================
module key_load_ctrl
    import key_load_pkg::*;
#(
    parameter int KEY_W  = 32,
    parameter int WORD_W = 8,
    parameter int TAG_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              zeroize_i,
    input  logic              nvm_valid_i,
    input  logic [WORD_W-1:0] nvm_data_i,
    output logic              nvm_ready_o,
    output logic [KEY_W-1:0]  key_out_o,
    output logic              key_valid_o,
    output logic              out_en_o,
    output logic              busy_o,
    output logic              error_o
);

    localparam int NWORDS = nwords(KEY_W, WORD_W);
    localparam int CNT_W  = cnt_width(NWORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

    // A key that is not a whole number of stream words cannot be assembled
    if ((KEY_W % WORD_W) != 0) begin : g_width_check
        $error("key_load_ctrl: KEY_W must be a multiple of WORD_W");
    end

    state_e            state_q;
    logic [KEY_W-1:0]  shadow_q;
    logic [KEY_W-1:0]  shadow_d;
    logic [KEY_W-1:0]  key_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              key_valid_q;
    logic              error_q;
    logic [WORD_W-1:0] tag_acc;

    logic in_stream;
    logic hs;
    logic start_ok;
    logic acc_clr;
    logic acc_en;

    assign in_stream = (state_q == ST_LOAD) || (state_q == ST_CHECK);
    assign hs        = nvm_valid_i & in_stream;
    // Start is honoured only outside a load and never alongside zeroize
    assign start_ok  = start_i & ~zeroize_i &
                       ((state_q == ST_IDLE) || (state_q == ST_ACTIVE) ||
                        (state_q == ST_FAIL));
    assign acc_clr   = zeroize_i | start_ok;
    assign acc_en    = hs & (state_q == ST_LOAD);

    key_tag_accum #(
        .WORD_W (WORD_W)
    ) u_tag (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (acc_clr),
        .en_i   (acc_en),
        .data_i (nvm_data_i),
        .acc_o  (tag_acc)
    );

    // Shadow image with the incoming word merged at the current slot
    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < NWORDS; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                shadow_d[i*WORD_W +: WORD_W] = nvm_data_i;
            end
        end
    end

    // Load sequencer: assemble, verify, commit, and fail-secure on reload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shadow_q    <= '0;
            key_q       <= '0;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            error_q     <= 1'b0;
        end else if (zeroize_i) begin
            state_q     <= ST_IDLE;
            shadow_q    <= '0;
            key_q       <= '0;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACTIVE, ST_FAIL: begin
                    if (start_i) begin
                        // Drop any live key before the new one is streamed in
                        state_q     <= ST_LOAD;
                        shadow_q    <= '0;
                        cnt_q       <= '0;
                        key_q       <= '0;
                        key_valid_q <= 1'b0;
                        error_q     <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (hs) begin
                        shadow_q <= shadow_d;
                        if (cnt_q == LAST_CNT) begin
                            cnt_q <= '0;
                            if (TAG_EN != 0) begin
                                state_q <= ST_CHECK;
                            end else begin
                                key_q       <= shadow_d;
                                key_valid_q <= 1'b1;
                                state_q     <= ST_ACTIVE;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (hs) begin
                        if (nvm_data_i == tag_acc) begin
                            key_q       <= shadow_q;
                            key_valid_q <= 1'b1;
                            state_q     <= ST_ACTIVE;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= ST_FAIL;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign nvm_ready_o = in_stream;
    assign busy_o      = in_stream;
    assign key_out_o   = key_q;
    assign key_valid_o = key_valid_q;
    assign out_en_o    = key_valid_q;
    assign error_o     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_key_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_load_ctrl
// Description : Directed bench for key_load_ctrl: a vector table for the
//               basic load/fail/reload flow plus hand sequences for gaps,
//               zeroize, mid-load start and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_load_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        zeroize;
    logic        nvm_valid;
    logic [7:0]  nvm_data;
    logic        nvm_ready;
    logic [31:0] key_out;
    logic        key_valid;
    logic        out_en;
    logic        busy;
    logic        error;

    int n_checks;
    int n_fail;

    key_load_ctrl #(
        .KEY_W  (32),
        .WORD_W (8),
        .TAG_EN (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .zeroize_i   (zeroize),
        .nvm_valid_i (nvm_valid),
        .nvm_data_i  (nvm_data),
        .nvm_ready_o (nvm_ready),
        .key_out_o   (key_out),
        .key_valid_o (key_valid),
        .out_en_o    (out_en),
        .busy_o      (busy),
        .error_o     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        zero;
        logic        valid;
        logic [7:0]  data;
        logic        e_ready;
        logic        e_kv;
        logic        e_busy;
        logic        e_err;
        logic [31:0] e_key;
    } vec_t;

    vec_t vt [19];

    function automatic vec_t mk(input logic s, input logic z, input logic v,
                                input logic [7:0] d, input logic r,
                                input logic kv, input logic b, input logic e,
                                input logic [31:0] k);
        vec_t x;
        x.start = s; x.zero = z; x.valid = v; x.data = d;
        x.e_ready = r; x.e_kv = kv; x.e_busy = b; x.e_err = e; x.e_key = k;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic r, input logic kv,
                           input logic b, input logic e, input logic [31:0] k);
        chk({name, " ready"}, {31'd0, nvm_ready}, {31'd0, r});
        chk({name, " key_valid"}, {31'd0, key_valid}, {31'd0, kv});
        chk({name, " out_en"}, {31'd0, out_en}, {31'd0, kv});
        chk({name, " busy"}, {31'd0, busy}, {31'd0, b});
        chk({name, " error"}, {31'd0, error}, {31'd0, e});
        chk({name, " key_out"}, key_out, k);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input int gap);
        nvm_valid = 1'b0;
        repeat (gap) step();
        nvm_valid = 1'b1;
        nvm_data  = d;
        step();
        nvm_valid = 1'b0;
        nvm_data  = 8'h00;
    endtask

    // Start, stream the four key bytes LSB first, then the given tag
    task automatic load_key(input logic [31:0] k, input logic [7:0] tag,
                            input int gap);
        pulse_start();
        for (int w = 0; w < 4; w++) send(k[w*8 +: 8], gap);
        send(tag, gap);
    endtask

    function automatic logic [7:0] xtag(input logic [31:0] k);
        return k[7:0] ^ k[15:8] ^ k[23:16] ^ k[31:24];
    endfunction

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        zeroize   = 1'b0;
        nvm_valid = 1'b0;
        nvm_data  = 8'h00;

        // Basic load, ignored stray word, reload, bad tag, recovery
        vt[0]  = mk(1, 0, 0, 8'h00, 1, 0, 1, 0, 32'h0);
        vt[1]  = mk(0, 0, 1, 8'h11, 1, 0, 1, 0, 32'h0);
        vt[2]  = mk(0, 0, 1, 8'h22, 1, 0, 1, 0, 32'h0);
        vt[3]  = mk(0, 0, 1, 8'h33, 1, 0, 1, 0, 32'h0);
        vt[4]  = mk(0, 0, 1, 8'h44, 1, 0, 1, 0, 32'h0);
        vt[5]  = mk(0, 0, 1, 8'h44, 0, 1, 0, 0, 32'h44332211);
        vt[6]  = mk(0, 0, 1, 8'h99, 0, 1, 0, 0, 32'h44332211);
        vt[7]  = mk(1, 0, 0, 8'h00, 1, 0, 1, 0, 32'h0);
        vt[8]  = mk(0, 0, 1, 8'h11, 1, 0, 1, 0, 32'h0);
        vt[9]  = mk(0, 0, 1, 8'h22, 1, 0, 1, 0, 32'h0);
        vt[10] = mk(0, 0, 1, 8'h33, 1, 0, 1, 0, 32'h0);
        vt[11] = mk(0, 0, 1, 8'h44, 1, 0, 1, 0, 32'h0);
        vt[12] = mk(0, 0, 1, 8'h45, 0, 0, 0, 1, 32'h0);
        vt[13] = mk(1, 0, 0, 8'h00, 1, 0, 1, 0, 32'h0);
        vt[14] = mk(0, 0, 1, 8'h11, 1, 0, 1, 0, 32'h0);
        vt[15] = mk(0, 0, 1, 8'h22, 1, 0, 1, 0, 32'h0);
        vt[16] = mk(0, 0, 1, 8'h33, 1, 0, 1, 0, 32'h0);
        vt[17] = mk(0, 0, 1, 8'h44, 1, 0, 1, 0, 32'h0);
        vt[18] = mk(0, 0, 1, 8'h44, 0, 1, 0, 0, 32'h44332211);

        // Reset state
        #12;
        chk_all("reset", 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_all("post_reset", 0, 0, 0, 0, 32'h0);

        for (int i = 0; i < 19; i++) begin
            start     = vt[i].start;
            zeroize   = vt[i].zero;
            nvm_valid = vt[i].valid;
            nvm_data  = vt[i].data;
            step();
            chk_all($sformatf("vec%0d", i), vt[i].e_ready, vt[i].e_kv,
                    vt[i].e_busy, vt[i].e_err, vt[i].e_key);
        end
        start = 1'b0; zeroize = 1'b0; nvm_valid = 1'b0; nvm_data = 8'h00;

        // Zeroize from ACTIVE, stray stream word in IDLE, gapped load
        zeroize = 1'b1;
        step();
        zeroize = 1'b0;
        chk_all("zeroize_active", 0, 0, 0, 0, 32'h0);
        nvm_valid = 1'b1;
        nvm_data  = 8'hAA;
        step();
        step();
        chk_all("idle_stray", 0, 0, 0, 0, 32'h0);
        nvm_valid = 1'b0;
        pulse_start();
        for (int w = 0; w < 4; w++) send(8'(32'hEFBEADDE >> (w*8)), 3);
        chk("gap_check_kv", {31'd0, key_valid}, 32'd0);
        send(8'h22, 3);
        chk_all("gap_load", 0, 1, 0, 0, 32'hEFBEADDE);

        // Zeroize after two accepted words leaves nothing behind
        pulse_start();
        send(8'hA5, 0);
        send(8'h5A, 0);
        zeroize = 1'b1;
        step();
        zeroize = 1'b0;
        chk_all("zeroize_midload", 0, 0, 0, 0, 32'h0);
        load_key(32'h04030201, 8'h04, 0);
        chk_all("post_zeroize_load", 0, 1, 0, 0, 32'h04030201);

        // Reload from ACTIVE drops the key the next cycle
        pulse_start();
        chk_all("reload_drop", 1, 0, 1, 0, 32'h0);
        send(8'h55, 0);
        send(8'h66, 1);
        // start during LOAD must not restart the stream
        pulse_start();
        send(8'h77, 0);
        send(8'h88, 0);
        send(xtag(32'h88776655), 0);
        chk_all("reload", 0, 1, 0, 0, 32'h88776655);

        // start and zeroize together, zeroize held: stay in IDLE
        start   = 1'b1;
        zeroize = 1'b1;
        step();
        start   = 1'b0;
        step();
        chk_all("start_zeroize", 0, 0, 0, 0, 32'h0);
        zeroize = 1'b0;
        step();
        chk_all("after_zeroize", 0, 0, 0, 0, 32'h0);

        // Asynchronous reset mid-load
        pulse_start();
        send(8'h12, 0);
        send(8'h34, 0);
        #3 rst_n = 1'b0;
        #1;
        chk_all("arst_load", 0, 0, 0, 0, 32'h0);
        rst_n = 1'b1;
        step();
        chk_all("arst_load_idle", 0, 0, 0, 0, 32'h0);

        // Asynchronous reset while a key is live
        load_key(32'hCAFEF00D, xtag(32'hCAFEF00D), 0);
        chk_all("pre_arst_active", 0, 1, 0, 0, 32'hCAFEF00D);
        #3 rst_n = 1'b0;
        #1;
        chk_all("arst_active", 0, 0, 0, 0, 32'h0);
        rst_n = 1'b1;
        step();
        chk_all("arst_active_idle", 0, 0, 0, 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
